fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h00000000: the fetch address that fetch_ctrl SHALL drive on next during and immediately after reset.
REQ-002 Parameter TIMEOUT_CYC, default 16: the number of REQ cycles without response before a fetch error (only with FETCH_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 ppc  in  32  current PC from the pc register.
REQ-006 next  out  32  next PC to the pc register (combinational from state and inputs); pc latches it every clk.
REQ-007 imem_req  out  1  instruction-memory request; held high until imem_rvalid.
REQ-008 imem_addr  out  32  request address (registered addr_q); stable while imem_req=1.
REQ-009 imem_rvalid  in  1  response strobe; single cycle.
REQ-010 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-011 br_taken  in  1  redirect strobe from execute.
REQ-012 br_target  in  32  redirect address, valid with br_taken.
REQ-013 instr  out  32  fetched instruction to decode.
REQ-014 instr_valid  out  1  instr holds a valid word.
REQ-015 instr_ready  in  1  decode accepts instr this cycle.
REQ-016 fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD, plus ERR when FETCH_TIMEOUT_EN is defined.
REQ-018 Default next = ppc (PC hold) in every state unless a rule below applies.
REQ-019 IDLE: imem_req=0; the FSM SHALL go to REQ the next cycle with addr_q <= ppc.
REQ-020 REQ: imem_req=1; on imem_rvalid (no kill, no br_taken), instr <= imem_rdata, instr_valid <= 1, go to HOLD.
REQ-021 HOLD: instr_valid=1, imem_req=0; on instr_ready, next = ppc+4, instr_valid <= 0, addr_q <= ppc+4, go to REQ.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles: REQ with same-cycle rvalid, then HOLD with ready.
REQ-023 ppc+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
REQ-024 br_taken in any non-ERR state SHALL take priority: next = {br_target[31:2],2'b00}, instr_valid <= 0, state <= REQ.
REQ-025 br_taken in REQ without same-cycle rvalid SHALL set kill; addr_q SHALL hold the old address until the killed response arrives.
REQ-026 In REQ with kill set, rvalid SHALL be discarded, kill cleared, addr_q <= ppc, state stays REQ.
REQ-027 br_taken in REQ with same-cycle rvalid SHALL discard the data, set no kill, and load addr_q <= aligned br_target.
REQ-028 br_taken with instr_ready in HOLD: the branch wins and the word is not counted as accepted.

Reset
REQ-029 Reset: state=IDLE, next=RESET_VEC, imem_req=0, addr_q=RESET_VEC, instr=0, instr_valid=0, kill=0, fetch_err=0, timeout counter=0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; a response arriving after reset deasserts, while in IDLE, SHALL be ignored.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN: when defined, a counter SHALL count consecutive REQ cycles without imem_rvalid; on reaching TIMEOUT_CYC, the FSM enters ERR: imem_req=0, fetch_err=1, next=ppc, ignore br_taken, exit only by reset.
REQ-032 Without FETCH_TIMEOUT_EN: no counter or ERR state; fetch_err SHALL be tied to 0 and REQ waits indefinitely.

Structure
REQ-033 Package fetch_pkg SHALL hold the state encoding, INSTR_BYTES=4, and the RESET_VEC default.
REQ-034 The timeout counter SHALL be sub-module fetch_timeout_ctr, instantiated only under FETCH_TIMEOUT_EN; everything else stays in fetch_ctrl (120-400 lines).

Verification
REQ-035 reset=1 for 2 cycles, then release; memory returns 32'h00000013 at 0 with 1-cycle latency, instr_ready=1 -> imem_addr=0, instr=32'h13, next=4 on accept.
REQ-036 instr_ready=0 for 3 cycles in HOLD -> instr_valid stays 1, instr stable, next=ppc, imem_req=0.
REQ-037 br_taken with br_target=32'h00000103 in REQ, response 3 cycles later -> that response dropped, next request at 32'h00000100.
REQ-038 ppc=32'hFFFFFFFC, word accepted -> next=32'h00000000.
REQ-039 With FETCH_TIMEOUT_EN and TIMEOUT_CYC=16, no rvalid -> fetch_err=1 after 16 REQ cycles, imem_req=0 until reset; without the macro, fetch_err stays 0.
REQ-040 reset asserted during REQ, with a late rvalid in IDLE -> instr_valid stays 0, next=RESET_VEC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction-fetch controller.
// The ERR state exists only when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;
`endif

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential next word; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive cycles with i_count high; o_expired marks the last one.
// Used by fetch_ctrl only when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_count;

  // A cycle without i_count breaks the run, so the count restarts.
  always_ff @(posedge clk) begin
    if (reset || !i_count) r_count <= '0;
    else                   r_count <= r_count + CW'(1);
  end

  assign o_expired = i_count && (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding request, a one-word holding
// register toward decode, and branch redirect. FETCH_TIMEOUT_EN adds ERR.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ppc,
  output logic [31:0] next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  fetch_state_e r_state;
  logic [31:0]  r_addr;
  logic         r_imem_req;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         r_kill;

  logic [31:0]  w_br_al;
  logic [31:0]  w_ppc_inc;
  logic         w_in_err;
  logic         w_expired;

  assign w_br_al   = align_word(br_target);
  assign w_ppc_inc = next_word(ppc);

`ifdef FETCH_TIMEOUT_EN
  logic r_fetch_err;

  assign w_in_err  = (r_state == ST_ERR);
  assign fetch_err = r_fetch_err;

  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_count   ((r_state == ST_REQ) && !imem_rvalid),
    .o_expired (w_expired)
  );
`else
  assign w_in_err  = 1'b0;
  assign w_expired = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // NOTE: next is assigned its default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next = ppc;
    if (reset)                                  next = RESET_VEC;
    else if (br_taken && !w_in_err)             next = w_br_al;
    else if (r_state == ST_HOLD && instr_ready) next = w_ppc_inc;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= RESET_VEC;
      r_imem_req    <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_kill        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_fetch_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Any response seen here belongs to a request abandoned by reset.
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
          r_addr     <= br_taken ? w_br_al : ppc;
        end
        ST_REQ: begin
          if (br_taken) begin
            // Without a response in hand the old request is still in flight,
            // so its address is held and the eventual reply is dropped.
            if (imem_rvalid) begin
              r_kill <= 1'b0;
              r_addr <= w_br_al;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_kill) begin
              r_kill <= 1'b0;
              r_addr <= ppc;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_valid <= 1'b1;
              r_imem_req    <= 1'b0;
              r_state       <= ST_HOLD;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          if (w_expired) begin
            r_state     <= ST_ERR;
            r_imem_req  <= 1'b0;
            r_fetch_err <= 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          if (br_taken || instr_ready) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= ST_REQ;
            r_addr        <= br_taken ? w_br_al : w_ppc_inc;
          end
        end
        default: ; // ERR is left only through reset
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: pc register and memory responder models,
// an instruction scoreboard, a branch vector table and hand-written corner cases.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] ppc = 32'hDEAD_BEEC;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  logic mem_en  = 1'b1;
  int   mem_lat = 1;
  int   mem_cnt = 0;
  logic mon_prev = 1'b0;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic        rdy;
    int          hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[4];

  fetch_ctrl #(.RESET_VEC(RST_VEC)) dut (
    .clk         (clk),
    .reset       (reset),
    .ppc         (ppc),
    .next        (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pc register: latches next on every edge.
  always @(posedge clk) ppc <= next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[31:2] ^ 30'h0A5A_5A5A, 2'b11};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!instr_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  // Memory: answers mem_lat cycles into a request, using the address on the bus.
  always @(negedge clk) begin
    if (mem_en) begin
      if (imem_req && !reset) begin
        if (mem_cnt >= mem_lat) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(imem_addr);
          mem_cnt     = 0;
        end else begin
          imem_rvalid = 1'b0;
          mem_cnt     = mem_cnt + 1;
        end
      end else begin
        imem_rvalid = 1'b0;
        mem_cnt     = 0;
      end
    end
  end

  // Scoreboard: every new valid word must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && instr_valid && !mon_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_instr: got 0x%h expected none", instr);
      end else begin
        check("scoreboard_instr", instr, exp_q.pop_front());
      end
    end
    mon_prev = reset ? 1'b0 : instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{target: 32'hFFFF_FFFF, lat: 0, rdy: 1'b1, hold: 0,
                exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    vecs[1] = '{target: 32'h0000_1235, lat: 2, rdy: 1'b0, hold: 1,
                exp_addr: 32'h0000_1234, exp_next: 32'h0000_1238};
    vecs[2] = '{target: 32'h7FFF_FFFE, lat: 1, rdy: 1'b1, hold: 2,
                exp_addr: 32'h7FFF_FFFC, exp_next: 32'h8000_0000};
    vecs[3] = '{target: 32'h8000_0000, lat: 0, rdy: 1'b0, hold: 0,
                exp_addr: 32'h8000_0000, exp_next: 32'h8000_0004};

    reset       = 1'b1;
    br_taken    = 1'b0;
    br_target   = '0;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset state and first fetch at address 0.
    @(posedge clk);
    @(negedge clk);
    check("rst_next", next_pc, RST_VEC);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_VEC);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    instr_ready = 1'b1;
    exp_q.push_back(32'h0000_0013);
    #1;
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_next", next_pc, RST_VEC);
    @(negedge clk);
    check("first_addr", imem_addr, 32'h0);
    check("first_req", 32'(imem_req), 32'd1);
    wait_valid("first_valid");
    check("first_instr", instr, 32'h0000_0013);
    check("first_next", next_pc, 32'h4);

    // Decode stalls for several cycles with a word held.
    @(negedge clk);
    instr_ready = 1'b0;
    exp_q.push_back(mem_word(32'h4));
    wait_valid("stall_valid");
    for (int k = 0; k < 3; k++) begin
      check("stall_valid_hold", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, mem_word(32'h4));
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_next", next_pc, 32'h4);
      @(negedge clk);
    end
    mem_lat     = 3;
    instr_ready = 1'b1;
    #1;
    check("stall_release_next", next_pc, 32'h8);

    // Branch while a slow request is in flight: the old reply is dropped.
    @(negedge clk);
    check("kill_old_addr", imem_addr, 32'h8);
    br_taken  = 1'b1;
    br_target = 32'h0000_0103;
    exp_q.push_back(mem_word(32'h100));
    #1;
    check("kill_br_next", next_pc, 32'h100);
    @(negedge clk);
    br_taken = 1'b0;
    check("kill_addr_held", imem_addr, 32'h8);
    check("kill_req", 32'(imem_req), 32'd1);
    check("kill_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 20 && imem_addr !== 32'h100; k++) @(negedge clk);
    check("kill_new_addr", imem_addr, 32'h100);
    wait_valid("kill_valid_after");
    check("kill_instr", instr, mem_word(32'h100));
    check("kill_accept_next", next_pc, 32'h104);
    mem_lat = 0;

    // Branch in the same cycle as a reply: reply discarded, no kill.
    @(negedge clk);
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    exp_q.push_back(mem_word(32'h200));
    #1;
    check("brrv_next", next_pc, 32'h200);
    @(negedge clk);
    br_taken = 1'b0;
    check("brrv_addr", imem_addr, 32'h200);
    check("brrv_req", 32'(imem_req), 32'd1);
    check("brrv_valid0", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("brrv_valid1", 32'(instr_valid), 32'd1);
    check("brrv_accept_next", next_pc, 32'h204);
    @(negedge clk);
    instr_ready = 1'b0;
    exp_q.push_back(mem_word(32'h204));

    // Branch-in-HOLD vectors, including wrap and branch-beats-ready.
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("vec%0d_hold", i));
      br_taken    = 1'b1;
      br_target   = vecs[i].target;
      instr_ready = vecs[i].rdy;
      mem_lat     = vecs[i].lat;
      exp_q.push_back(mem_word(vecs[i].exp_addr));
      #1;
      check($sformatf("vec%0d_br_next", i), next_pc, vecs[i].exp_addr);
      @(negedge clk);
      br_taken    = 1'b0;
      instr_ready = 1'b0;
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid0", i), 32'(instr_valid), 32'd0);
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].exp_addr));
      repeat (vecs[i].hold) begin
        @(negedge clk);
        check($sformatf("vec%0d_held", i), 32'(instr_valid), 32'd1);
      end
      instr_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_accept_next", i), next_pc, vecs[i].exp_next);
      @(negedge clk);
      instr_ready = 1'b0;
      exp_q.push_back(mem_word(vecs[i].exp_next));
    end

    // Reset during REQ, then a stale reply while in IDLE.
    wait_valid("rstreq_hold");
    mem_lat     = 2;
    instr_ready = 1'b1;
    @(negedge clk);
    mem_en      = 1'b0;
    imem_rvalid = 1'b0;
    reset       = 1'b1;
    #1;
    check("rstreq_next", next_pc, RST_VEC);
    @(negedge clk);
    check("rstreq_req", 32'(imem_req), 32'd0);
    check("rstreq_valid", 32'(instr_valid), 32'd0);
    check("rstreq_addr", imem_addr, RST_VEC);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0001;
    #1;
    check("late_idle_next", next_pc, RST_VEC);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_valid", 32'(instr_valid), 32'd0);
    check("late_req", 32'(imem_req), 32'd1);
    check("late_addr", imem_addr, RST_VEC);
    mem_cnt = 0;
    mem_en  = 1'b1;
    exp_q.push_back(32'h0000_0013);
    wait_valid("refetch_valid");
    check("refetch_instr", instr, 32'h0000_0013);
    check("refetch_next", next_pc, 32'h4);

    // Memory stops answering.
    @(negedge clk);
    mem_en      = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    repeat (15) @(negedge clk);
    check("to_err_before", 32'(fetch_err), 32'd0);
    check("to_req_before", 32'(imem_req), 32'd1);
    @(negedge clk);
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
`ifdef FETCH_TIMEOUT_EN
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_req", 32'(imem_req), 32'd0);
    #1;
    check("to_br_ignored", next_pc, 32'h4);
`else
    check("to_no_err", 32'(fetch_err), 32'd0);
    check("to_still_req", 32'(imem_req), 32'd1);
    check("to_addr", imem_addr, 32'h4);
    #1;
    check("to_br_next", next_pc, 32'h300);
`endif
    @(negedge clk);
    br_taken = 1'b0;
    check("to_err_after", 32'(fetch_err), 32'(`ifdef FETCH_TIMEOUT_EN 1 `else 0 `endif));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("final_rst_err", 32'(fetch_err), 32'd0);
    check("final_rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
